control_sequencer: RTL and testbench

//  Hardwired control unit driving data_path's control inputs, replacing the hand-timed testbench FSM.

---
 rtl/mini_cpu_ctrl_pkg.sv | 56 +++++
 rtl/control_sequencer.sv | 138 +++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mini_cpu_ctrl_pkg.sv
// rtl/mini_cpu_ctrl_pkg.sv - state, opcode and ALU encodings shared by the control sequencer
package mini_cpu_ctrl_pkg;

  // One state per clock: reset, eight timing steps, halt
  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  // Instruction families that share an execute sequence
  typedef enum logic [3:0] {
    C_NONE, C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_BR, C_IN, C_OUT, C_HALT
  } op_class_t;

  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_LDI       = 5'b00001;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_ADDI      = 5'b01100;
  localparam logic [4:0] OP_ANDI      = 5'b01101;
  localparam logic [4:0] OP_ORI       = 5'b01110;
  localparam logic [4:0] OP_BR        = 5'b10010;
  localparam logic [4:0] OP_IN        = 5'b10110;
  localparam logic [4:0] OP_OUT       = 5'b10111;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  // Must match the data_path ALU operation encoding
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  // nop and every unassigned opcode fall into C_NONE (fetch only)
  function automatic op_class_t classify(input logic [4:0] opcode);
    if (opcode == OP_LD)                                           return C_LD;
    else if (opcode == OP_LDI)                                     return C_LDI;
    else if (opcode == OP_ST)                                      return C_ST;
    else if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST)      return C_RALU;
    else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) return C_IALU;
    else if (opcode == OP_BR)                                      return C_BR;
    else if (opcode == OP_IN)                                      return C_IN;
    else if (opcode == OP_OUT)                                     return C_OUT;
    else if (opcode == OP_HALT)                                    return C_HALT;
    else                                                           return C_NONE;
  endfunction

  // Immediate forms reuse the register ALU with a fixed operation
  function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T7 control unit for the mini CPU data path
module control_sequencer
  import mini_cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            branchCompare,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZHighin,
  output logic            Zlowin,
  output logic            HIin,
  output logic            LOin,
  output logic            OutPortin,
  output logic            CONin,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic [OP_W-1:0] op,
  output logic            run
);

  state_t          state;
  logic [OP_W-1:0] opcode;
  op_class_t       cls;
  logic            unused_ir_low;

  assign opcode        = ir[IR_W-1 -: OP_W];
  assign cls           = classify(opcode);
  assign unused_ir_low = ^ir[IR_W-OP_W-1:0];

  // Step through fetch, then the execute length of the decoded instruction
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:  state <= T0;
        T0:     state <= T1;
        T1:     state <= T2;
        T2: begin
          if (cls == C_HALT)      state <= S_HALT;
          else if (cls == C_NONE) state <= T0;
          else                    state <= T3;
        end
        T3:     state <= (cls == C_IN || cls == C_OUT) ? T0 : T4;
        T4:     state <= T5;
        T5:     state <= (cls == C_LD || cls == C_ST || cls == C_BR) ? T6 : T0;
        T6:     state <= (cls == C_LD || cls == C_ST) ? T7 : T0;
        T7:     state <= T0;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Decode strobes from state (and opcode in execute); clear drops them with the state
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; ZHighin = 1'b0; Zlowin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    OutPortin = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    op  = '0;
    run = (state != S_HALT);
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_RALU, C_IALU:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_IN:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = ALU_ADD; end
          C_RALU: begin Grc = 1'b1; Rout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = opcode; end
          C_IALU: begin Cout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = imm_alu_op(opcode); end
          C_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_LD, C_ST:             begin Zlowout = 1'b1; MARin = 1'b1; end
          C_LDI, C_RALU, C_IALU:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_BR: begin Cout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = ALU_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_LD: begin Read = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR: begin Zlowout = branchCompare; PCin = branchCompare; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        Clock, clear, branchCompare;
  logic [31:0] ir;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin, OutPortin, CONin;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [4:0] op;

  control_sequencer #(.IR_W(32), .OP_W(5)) dut (
    .Clock(Clock), .clear(clear), .ir(ir), .branchCompare(branchCompare),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .CONin(CONin), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .op(op), .run(run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [27:0] ctrl_w;
  assign ctrl_w = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
                   PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin,
                   OutPortin, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

  localparam logic [27:0] M_BAOUT = 28'd1 << 0,  M_ROUT = 28'd1 << 1,  M_RIN = 28'd1 << 2;
  localparam logic [27:0] M_GRC = 28'd1 << 3,    M_GRB = 28'd1 << 4,   M_GRA = 28'd1 << 5;
  localparam logic [27:0] M_WRITE = 28'd1 << 6,  M_READ = 28'd1 << 7,  M_CONIN = 28'd1 << 8;
  localparam logic [27:0] M_OUTPORTIN = 28'd1 << 9, M_ZLOWIN = 28'd1 << 12, M_ZHIGHIN = 28'd1 << 13;
  localparam logic [27:0] M_YIN = 28'd1 << 14,   M_IRIN = 28'd1 << 15, M_MDRIN = 28'd1 << 16;
  localparam logic [27:0] M_MARIN = 28'd1 << 17, M_INCPC = 28'd1 << 18, M_PCIN = 28'd1 << 19;
  localparam logic [27:0] M_COUT = 28'd1 << 20,  M_INPORTOUT = 28'd1 << 21;
  localparam logic [27:0] M_MDROUT = 28'd1 << 24, M_ZLOWOUT = 28'd1 << 25, M_PCOUT = 28'd1 << 27;
  localparam logic [27:0] M_ZIN = M_ZHIGHIN | M_ZLOWIN;
  localparam logic [27:0] FETCH0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [27:0] FETCH1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [27:0] FETCH2 = M_MDROUT | M_IRIN;
  localparam logic [4:0]  A_ADD = 5'b00011, A_AND = 5'b00101, A_OR = 5'b00110;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [27:0] ctrl; logic [4:0] op; } step_t;
  step_t exp_q[$];

  typedef struct {
    logic [4:0]  opc;
    logic        bc;
    int          len;
    logic [27:0] t3;
    logic [4:0]  t4op;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [27:0] ec, input logic [4:0] eop, input logic erun);
    checks++;
    if (ctrl_w !== ec || op !== eop || run !== erun) begin
      errors++;
      $display("FAIL %s: ctrl=%h op=%b run=%b, expected ctrl=%h op=%b run=%b",
               name, ctrl_w, op, run, ec, eop, erun);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push(input logic [27:0] c, input logic [4:0] o);
    step_t s;
    s.ctrl = c;
    s.op   = o;
    exp_q.push_back(s);
  endtask

  // Reference: full per-cycle control sequence of one instruction, fetch included
  task automatic build_expect(input logic [4:0] opc, input logic bc);
    logic [4:0] imm_ops[3];
    imm_ops[0] = A_ADD; imm_ops[1] = A_AND; imm_ops[2] = A_OR;
    exp_q.delete();
    push(FETCH0, 5'd0); push(FETCH1, 5'd0); push(FETCH2, 5'd0);
    if (opc <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, A_ADD);
      if (opc == 5'd1) push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLOWOUT | M_MARIN, 5'd0);
        if (opc == 5'd0) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
    end else if (opc <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZIN, opc);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
    end else if (opc <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, imm_ops[opc - 5'd12]);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
    end else if (opc == 5'd18) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0);
      push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, A_ADD);
      push(bc ? (M_ZLOWOUT | M_PCIN) : 28'd0, 5'd0);
    end else if (opc == 5'd22) begin
      push(M_INPORTOUT | M_GRA | M_RIN, 5'd0);
    end else if (opc == 5'd23) begin
      push(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0);
    end
  endtask

  initial begin
    int cycles;
    logic [27:0] cap3;
    logic [4:0]  cap4;
    logic [4:0]  opc;
    logic        bc;

    vecs[0]  = '{5'b00011, 1'b0, 6, M_GRB | M_ROUT | M_YIN, 5'b00011};
    vecs[1]  = '{5'b00100, 1'b0, 6, M_GRB | M_ROUT | M_YIN, 5'b00100};
    vecs[2]  = '{5'b01011, 1'b0, 6, M_GRB | M_ROUT | M_YIN, 5'b01011};
    vecs[3]  = '{5'b00000, 1'b0, 8, M_GRB | M_BAOUT | M_YIN, A_ADD};
    vecs[4]  = '{5'b00001, 1'b0, 6, M_GRB | M_BAOUT | M_YIN, A_ADD};
    vecs[5]  = '{5'b00010, 1'b1, 8, M_GRB | M_BAOUT | M_YIN, A_ADD};
    vecs[6]  = '{5'b01100, 1'b0, 6, M_GRB | M_ROUT | M_YIN, A_ADD};
    vecs[7]  = '{5'b01101, 1'b0, 6, M_GRB | M_ROUT | M_YIN, A_AND};
    vecs[8]  = '{5'b01110, 1'b0, 6, M_GRB | M_ROUT | M_YIN, A_OR};
    vecs[9]  = '{5'b10010, 1'b1, 7, M_GRA | M_ROUT | M_CONIN, 5'd0};
    vecs[10] = '{5'b10010, 1'b0, 7, M_GRA | M_ROUT | M_CONIN, 5'd0};
    vecs[11] = '{5'b10110, 1'b0, 4, M_INPORTOUT | M_GRA | M_RIN, 5'd0};
    vecs[12] = '{5'b10111, 1'b0, 4, M_GRA | M_ROUT | M_OUTPORTIN, 5'd0};
    vecs[13] = '{5'b11010, 1'b0, 3, FETCH0, 5'd0};
    vecs[14] = '{5'b10000, 1'b0, 3, FETCH0, 5'd0};
    vecs[15] = '{5'b11111, 1'b1, 3, FETCH0, 5'd0};

    clear = 1'b1; ir = 32'd0; branchCompare = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_state", 28'd0, 5'd0, 1'b1);
    clear = 1'b0;
    @(negedge Clock);
    check("t0_after_reset", FETCH0, 5'd0, 1'b1);

    // Table: instruction length, T3 controls and T4 ALU op measured from the DUT
    for (int i = 0; i < 16; i++) begin
      ir = {vecs[i].opc, 27'($urandom)};
      branchCompare = vecs[i].bc;
      cycles = 0; cap3 = FETCH0; cap4 = 5'd0;
      do begin
        @(negedge Clock);
        cycles++;
        if (cycles == 3) cap3 = ctrl_w;
        if (cycles == 4) cap4 = op;
      end while (!(ctrl_w == FETCH0 && run) && cycles < 20);
      check_val($sformatf("len_op%b", vecs[i].opc), 32'(cycles), 32'(vecs[i].len));
      check_val($sformatf("t3_op%b", vecs[i].opc), 32'(cap3), 32'(vecs[i].t3));
      check_val($sformatf("t4alu_op%b", vecs[i].opc), 32'(cap4), 32'(vecs[i].t4op));
    end

    // Random instruction stream against the reference sequence
    for (int k = 0; k < 200; k++) begin
      opc = 5'($urandom_range(0, 31));
      if (k % 8 == 0) opc = 5'b10010;
      if (opc == 5'b11011) opc = 5'b11010;
      bc = 1'($urandom);
      ir = {opc, 27'($urandom)};
      branchCompare = bc;
      build_expect(opc, bc);
      for (int j = 0; j < exp_q.size(); j++) begin
        check($sformatf("rand%0d_op%b_bc%b_step%0d", k, opc, bc, j), exp_q[j].ctrl, exp_q[j].op, 1'b1);
        @(negedge Clock);
      end
      check($sformatf("rand%0d_return_t0", k), FETCH0, 5'd0, 1'b1);
    end

    // Halt holds with no strobes until clear
    ir = {5'b11011, 27'($urandom)};
    repeat (3) @(negedge Clock);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt_cycle%0d", c), 28'd0, 5'd0, 1'b0);
      @(negedge Clock);
    end
    ir = 32'd0;
    clear = 1'b1;
    #1 check("halt_clear", 28'd0, 5'd0, 1'b1);
    @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);
    check("halt_restart_t0", FETCH0, 5'd0, 1'b1);

    // Clear during ld T6 drops Read without waiting for a clock
    ir = {5'b00000, 27'($urandom)};
    repeat (6) @(negedge Clock);
    check("ld_t6_read", M_READ | M_MDRIN, 5'd0, 1'b1);
    clear = 1'b1;
    #1 check("clear_async_drop", 28'd0, 5'd0, 1'b1);
    @(negedge Clock);
    check("clear_held", 28'd0, 5'd0, 1'b1);
    clear = 1'b0;
    @(negedge Clock);
    check("clear_restart_t0", FETCH0, 5'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
